// File: rtl/regfile_pkg.sv
// regfile_pkg: shared opcode, default register table, FSM states and default-value helper for regfile_param
package regfile_pkg;
  localparam logic [3:0] OPC_TYPEA = 4'hF;
  localparam logic [15:0] DEFAULT_TABLE [16] = '{
    16'h0000, 16'h0F00, 16'h0050, 16'hFF0F, 16'hF0FF, 16'h0040, 16'h6666, 16'h00FF,
    16'hFF88, 16'h0000, 16'h0000, 16'h0000, 16'hCCCC, 16'h0002, 16'h0000, 16'h0000
  };
  typedef enum logic {INIT, RUN} state_t;
  function automatic logic [63:0] default_val(input int idx, input int data_w);
    logic [63:0] v;
    v = (idx < 0 || idx > 15) ? 64'd0 : 64'(DEFAULT_TABLE[idx]);
    return (data_w >= 64) ? v : v & ((64'd1 << data_w) - 64'd1);
  endfunction
endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: operand bus; master drives instruc_in/RegWrite/wr_addr/Writedata, slave returns op1/op2/op_valid/ready
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instruc_in;
  logic RegWrite;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] Writedata;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic op_valid;
  logic ready;
  modport master (output instruc_in, RegWrite, wr_addr, Writedata, input op1, op2, op_valid, ready);
  modport slave (input instruc_in, RegWrite, wr_addr, Writedata, output op1, op2, op_valid, ready);
endinterface

// File: rtl/regfile_init_ctrl.sv
// regfile_init_ctrl: post-reset INIT/RUN FSM; ports clk, reset in; ready, init_we, init_addr, init_data out (one table entry per cycle)
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter bit R0_ZERO = 0
) (
  input  logic clk,
  input  logic reset,
  output logic ready,
  output logic init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) cnt <= cnt + ADDR_W'(1);
    end
  always_comb begin
    state_n = (state == INIT && cnt == ADDR_W'(DEPTH - 1)) ? RUN : state;
    init_we = state == INIT;
    init_addr = cnt;
    init_data = (R0_ZERO && cnt == '0) ? '0 : DATA_W'(default_val(int'(cnt), DATA_W));
  end
  assign ready = state == RUN;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: 2R/1W register file with table init, optional bypass and zero R0; ports clk, reset, bus (regfile_param_if.slave)
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int INSTR_W = 16,
  parameter logic [3:0] READ_OPC = OPC_TYPEA,
  parameter bit BYPASS = 1,
  parameter bit R0_ZERO = 0
) (
  input logic clk,
  input logic reset,
  regfile_param_if.slave bus
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic ready, init_we, rd_en;
  logic [ADDR_W-1:0] init_addr, src1, src2;
  logic [DATA_W-1:0] init_data, v1, v2;
  regfile_init_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .R0_ZERO(R0_ZERO)) init_ctrl (
    .clk(clk),
    .reset(reset),
    .ready(ready),
    .init_we(init_we),
    .init_addr(init_addr),
    .init_data(init_data)
  );
  // Storage is deliberately not reset; the INIT pass rewrites every entry.
  always_ff @(posedge clk)
    if (init_we) mem[init_addr] <= init_data;
    else if (ready && bus.RegWrite && !(R0_ZERO && bus.wr_addr == '0)) mem[bus.wr_addr] <= bus.Writedata;
  always_comb begin
    src1 = bus.instruc_in[INSTR_W-5 -: ADDR_W];
    src2 = bus.instruc_in[INSTR_W-5-ADDR_W -: ADDR_W];
    rd_en = ready && bus.instruc_in[INSTR_W-1 -: 4] == READ_OPC;
    v1 = (R0_ZERO && src1 == '0) ? '0 : (BYPASS && bus.RegWrite && bus.wr_addr == src1) ? bus.Writedata : mem[src1];
    v2 = (R0_ZERO && src2 == '0) ? '0 : (BYPASS && bus.RegWrite && bus.wr_addr == src2) ? bus.Writedata : mem[src2];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.op1 <= '0;
      bus.op2 <= '0;
      bus.op_valid <= 1'b0;
    end else begin
      bus.op_valid <= rd_en;
      if (rd_en) begin
        bus.op1 <= v1;
        bus.op2 <= v2;
      end
    end
  assign bus.ready = ready;
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised 2-read/1-write register file feeding operands to the ALU stage of the datapath.
- Decodes source fields from the fetched instruction and registers both operands.
- Optional write-to-read bypass and an optional hardwired-zero R0.
- After reset, a sequential init engine loads a per-register default table. `ready` is asserted once the table is loaded.

Parameters:
- DATA_W, 16, register and operand width.
- DEPTH, 16, number of registers (power of 2, ≥ 2).
- ADDR_W, 4, register index width; must equal clog2(DEPTH).
- INSTR_W, 16, instruction width; must satisfy INSTR_W ≥ 4 + 2*ADDR_W.
- READ_OPC, 4'hF, opcode in instruc_in[INSTR_W-1 -: 4] that triggers an operand read (Type A).
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = the read returns the old register contents.
- R0_ZERO, 0, 1 = register 0 reads as 0 and ignores writes.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- instruc_in, input, INSTR_W, current instruction; src1 = [INSTR_W-5 -: ADDR_W], src2 = [INSTR_W-5-ADDR_W -: ADDR_W].
- RegWrite, input, 1, write enable.
- wr_addr, input, ADDR_W, write destination index.
- Writedata, input, DATA_W, write data.
- op1, output, DATA_W, registered operand for src1.
- op2, output, DATA_W, registered operand for src2.
- op_valid, output, 1, one-cycle pulse; op1/op2 were updated on this edge.
- ready, output, 1, high when init is complete and the file accepts reads and writes.

Behaviour:
- Reset (asynchronous, active-high, effective immediately, including mid-init or mid-operation):
  - op1 = 0, op2 = 0, op_valid = 0, ready = 0.
  - init_cnt = 0, state = INIT.
  - Register contents are not cleared by reset itself; the INIT pass overwrites them.
- FSM state INIT:
  - Each cycle, register[init_cnt] ← DEFAULT_TABLE[init_cnt], then init_cnt increments.
  - Indices ≥ 16 load 0. With R0_ZERO = 1, index 0 loads 0.
  - When init_cnt = DEPTH-1 is written, go to RUN; ready rises on that same edge.
  - INIT therefore lasts exactly DEPTH cycles after reset deasserts; first RUN cycle is cycle DEPTH.
  - RegWrite and read opcodes are ignored in INIT. op_valid stays 0 and op1/op2 hold 0.
- FSM state RUN (terminal until the next reset):
  - Write: if RegWrite, register[wr_addr] ← Writedata at the edge. If R0_ZERO and wr_addr = 0, the write is dropped.
  - Read: if opcode field = READ_OPC:
    - op1 ← value(src1) and op2 ← value(src2) at the edge, with op_valid = 1 for the following cycle. Latency is 1 clock.
    - Otherwise op1/op2 hold their previous values and op_valid = 0.
  - value(a):
    - 0 if R0_ZERO and a = 0;
    - else Writedata if BYPASS and RegWrite and wr_addr = a (write-first);
    - else register[a].
  - src1 = src2 is legal; both ports return the same value.
  - A write and a read to the same address in the same cycle with BYPASS = 0 returns the old value; the new value is visible from the next cycle.
- No arithmetic; widths are exact and there is no truncation. Out-of-range indices cannot occur because DEPTH = 2^ADDR_W.

Decomposition:
- Package regfile_pkg:
  - OPC_TYPEA = 4'hF.
  - DEFAULT_TABLE[0:15] = 0000, 0F00, 0050, FF0F, F0FF, 0040, 6666, 00FF, FF88, 0000, 0000, 0000, CCCC, 0002, 0000, 0000 (16-bit).
  - state enum {INIT, RUN}.
  - function default_val(idx, DATA_W): zero-extends or truncates the table entry; returns 0 for idx ≥ 16.
- One sub-module: regfile_init_ctrl, holding the init counter, FSM, ready, and the init write address/data/enable. The storage array and read muxes stay in the top.

Test Plan:
- Release reset, then wait: ready = 0 for 16 cycles and rises on cycle 16. Read instruc_in = 16'hF120 → next cycle op1 = 16'h0F00, op2 = 16'h0050, op_valid = 1.
- RUN, RegWrite = 1, wr_addr = 3, Writedata = 16'hABCD, same cycle instruc_in = 16'hF340:
  - BYPASS = 1 → op1 = ABCD, op2 = F0FF.
  - BYPASS = 0 → op1 = FF0F; the same read repeated one cycle later → op1 = ABCD.
- R0_ZERO = 1: write 16'h1234 to addr 0, then read instruc_in = 16'hF0D0 → op1 = 0000, op2 = 0002.
- Non-read opcode instruc_in = 16'h1120 after a valid read → op_valid = 0, op1/op2 unchanged.
- Assert reset at init_cnt = 7 and again in RUN after writing reg 5 = 16'hBEEF:
  - Outputs go 0 asynchronously and ready = 0.
  - After a full re-init, reading reg 5 (instruc_in = 16'hF550) → op1 = op2 = 16'h0040.
- RegWrite to addr 2 = 16'h7777 during INIT is ignored: reading 16'hF200 after ready → op1 = 16'h0050.
